// File: rtl/audio_pkg.sv
// Shared types and constants for the 16-bit left-justified audio serial link.
package audio_pkg;

  localparam int DATA_WIDTH = 16;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  localparam logic LRCK_LEFT      = 1'b1;
  localparam int   BCK_HALF_CLKS  = 6;
  localparam int   LRCK_HALF_CLKS = 192;

  typedef enum logic {
    UNSYNC = 1'b0,
    RX     = 1'b1
  } rx_state_e;

endpackage

// File: rtl/audio_sync_edge.sv
// Multi-stage input synchronizer with optional registered rise/fall strobes.
// Strobes appear SYNC_STAGES+1 clocks after the pin edge.
module audio_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGES       = 1'b0
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iD,
  output logic oQ,
  output logic oRISE,
  output logic oFALL
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) sync_q <= '0;
    else      sync_q <= SYNC_STAGES'({sync_q, iD});
  end

  assign oQ = sync_q[SYNC_STAGES-1];

  if (EDGES) begin : g_edges
    logic prev_q, rise_q, fall_q;

    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        prev_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        prev_q <= oQ;
        rise_q <= oQ & ~prev_q;
        fall_q <= ~oQ & prev_q;
      end
    end

    assign oRISE = rise_q;
    assign oFALL = fall_q;
  end else begin : g_level
    assign oRISE = 1'b0;
    assign oFALL = 1'b0;
  end

endmodule

// File: rtl/audio_codec_slave.sv
// Codec-side end of the audio serial link: deserializes DAC L/R pairs from
// the master and serializes ADC samples back, all oversampled by iCLK.
module audio_codec_slave
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH     = audio_pkg::DATA_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iAUD_BCK,
  input  logic                  iAUD_LRCK,
  input  logic                  iAUD_DACDAT,
  output logic                  oAUD_ADCDAT,
  input  logic [DATA_WIDTH-1:0] iADC_L,
  input  logic [DATA_WIDTH-1:0] iADC_R,
  output logic [DATA_WIDTH-1:0] oDAC_L,
  output logic [DATA_WIDTH-1:0] oDAC_R,
  output logic                  oDAC_VALID,
  output logic                  oFRAME_ERR,
  output logic                  oLOCKED
);

  localparam int            CW   = $clog2(DATA_WIDTH + 1);
  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

  logic bck_rise, bck_fall, lrck_s, dac_s;
  logic bck_level_unused, lrck_rise_unused, lrck_fall_unused;
  logic dac_rise_unused, dac_fall_unused;

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGES(1'b1)) u_bck_sync (
    .iCLK(iCLK), .iRST(iRST), .iD(iAUD_BCK),
    .oQ(bck_level_unused), .oRISE(bck_rise), .oFALL(bck_fall)
  );
  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGES(1'b0)) u_lrck_sync (
    .iCLK(iCLK), .iRST(iRST), .iD(iAUD_LRCK),
    .oQ(lrck_s), .oRISE(lrck_rise_unused), .oFALL(lrck_fall_unused)
  );
  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGES(1'b0)) u_dac_sync (
    .iCLK(iCLK), .iRST(iRST), .iD(iAUD_DACDAT),
    .oQ(dac_s), .oRISE(dac_rise_unused), .oFALL(dac_fall_unused)
  );

  // Link watchdog: a strobe always restarts it, so a strobe beats a timeout.
  logic [TW-1:0] to_cnt_q;
  logic          bck_edge, timeout;

  assign bck_edge = bck_rise | bck_fall;
  assign timeout  = !bck_edge && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                                  to_cnt_q <= '0;
    else if (bck_edge)                         to_cnt_q <= '0;
    else if (to_cnt_q != TW'(TIMEOUT_CYCLES))  to_cnt_q <= to_cnt_q + 1'b1;
  end

  // Receive FSM and its datapath.
  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, left_hold_q, left_hold_d;
  logic                  last_lrck_q, last_lrck_d, left_vld_q, left_vld_d;
  logic                  commit_q, commit_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] first_bit;

  assign first_bit = {{(DATA_WIDTH-1){1'b0}}, dac_s};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    last_lrck_d = last_lrck_q;
    left_hold_d = left_hold_q;
    left_vld_d  = left_vld_q;
    commit_d    = 1'b0;
    err_d       = 1'b0;

    if (bck_rise) begin
      last_lrck_d = lrck_s;
      unique case (state_q)
        UNSYNC: begin
          if (lrck_s != last_lrck_q) begin
            state_d    = RX;
            shift_d    = first_bit;
            cnt_d      = CW'(1);
            left_vld_d = 1'b0;
          end
        end
        RX: begin
          if (lrck_s == last_lrck_q) begin
            if (cnt_q < FULL) begin
              shift_d = {shift_q[DATA_WIDTH-2:0], dac_s};
              cnt_d   = cnt_q + 1'b1;
              // Right word finishing with a left word already held.
              commit_d = (cnt_q == FULL - 1'b1) && (lrck_s != LRCK_LEFT) && left_vld_q;
            end
          end else begin
            if (cnt_q == FULL) begin
              if (last_lrck_q == LRCK_LEFT) begin
                left_hold_d = shift_q;
                left_vld_d  = 1'b1;
              end else begin
                left_vld_d  = 1'b0;
              end
            end else begin
              err_d      = 1'b1;
              left_vld_d = 1'b0;
            end
            shift_d = first_bit;
            cnt_d   = CW'(1);
          end
        end
        default: state_d = UNSYNC;
      endcase
    end else if (timeout) begin
      state_d    = UNSYNC;
      left_vld_d = 1'b0;
    end
  end

  // NOTE: holding and shift registers are plain flops, not memories, and the
  // outputs must read 0 in reset, so all of them take the async reset.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= UNSYNC;
      cnt_q       <= '0;
      shift_q     <= '0;
      last_lrck_q <= 1'b0;
      left_hold_q <= '0;
      left_vld_q  <= 1'b0;
      commit_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      last_lrck_q <= last_lrck_d;
      left_hold_q <= left_hold_d;
      left_vld_q  <= left_vld_d;
      commit_q    <= commit_d;
      err_q       <= err_d;
    end
  end

  logic [DATA_WIDTH-1:0] dac_l_q, dac_r_q;
  logic                  dac_valid_q, locked_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      dac_l_q     <= '0;
      dac_r_q     <= '0;
      dac_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      dac_valid_q <= commit_q;
      if (commit_q) begin
        dac_l_q <= left_hold_q;
        dac_r_q <= shift_q;
      end
      if (err_d || timeout) locked_q <= 1'b0;
      else if (commit_q)    locked_q <= 1'b1;
    end
  end

  // Transmit: ADC sample latched only when the word starts.
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_load;
  logic [CW-1:0]         tx_cnt_q;
  logic                  tx_bit_q, last_lrck_tx_q;

  assign tx_load = (lrck_s == LRCK_LEFT) ? iADC_L : iADC_R;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_bit_q       <= 1'b0;
      last_lrck_tx_q <= 1'b0;
    end else if (bck_fall) begin
      last_lrck_tx_q <= lrck_s;
      if (lrck_s != last_lrck_tx_q) begin
        tx_shift_q <= tx_load;
        tx_bit_q   <= tx_load[DATA_WIDTH-1];
        tx_cnt_q   <= CW'(1);
      end else if (tx_cnt_q < FULL) begin
        tx_shift_q <= tx_shift_q << 1;
        tx_bit_q   <= tx_shift_q[DATA_WIDTH-2];
        tx_cnt_q   <= tx_cnt_q + 1'b1;
      end else begin
        tx_bit_q   <= 1'b0;
      end
    end else if (timeout) begin
      tx_bit_q <= 1'b0;
      tx_cnt_q <= FULL;
    end
  end

  assign oAUD_ADCDAT = tx_bit_q;
  assign oDAC_L      = dac_l_q;
  assign oDAC_R      = dac_r_q;
  assign oDAC_VALID  = dac_valid_q;
  assign oFRAME_ERR  = err_q;
  assign oLOCKED     = locked_q;

endmodule

// File: tb/tb_audio_codec_slave.sv
// Self-checking bench: a master model drives BCK/LRCK/DACDAT at nominal
// timing and captures ADCDAT on BCK falls; frames come from a vector table.
module tb_audio_codec_slave;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iAUD_BCK = 1'b0, iAUD_LRCK = 1'b0, iAUD_DACDAT = 1'b0;
  logic        oAUD_ADCDAT;
  logic [15:0] iADC_L = '0, iADC_R = '0;
  logic [15:0] oDAC_L, oDAC_R;
  logic        oDAC_VALID, oFRAME_ERR, oLOCKED;

  always #5 iCLK = ~iCLK;

  audio_codec_slave #(.DATA_WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iAUD_BCK(iAUD_BCK), .iAUD_LRCK(iAUD_LRCK), .iAUD_DACDAT(iAUD_DACDAT),
    .oAUD_ADCDAT(oAUD_ADCDAT), .iADC_L(iADC_L), .iADC_R(iADC_R),
    .oDAC_L(oDAC_L), .oDAC_R(oDAC_R), .oDAC_VALID(oDAC_VALID),
    .oFRAME_ERR(oFRAME_ERR), .oLOCKED(oLOCKED)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse counters sampled away from the active edge.
  int valid_cnt = 0;
  int err_cnt   = 0;
  always @(negedge iCLK) begin
    if (oDAC_VALID === 1'b1) valid_cnt++;
    if (oFRAME_ERR === 1'b1) err_cnt++;
  end

  // Master-side ADCDAT capture state.
  logic [15:0] cap_sh = '0, cap_l = '0, cap_r = '0;
  int          prev_idx = -1;
  logic        prev_lr = 1'b0;
  bit          tog = 1'b0;

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(negedge iCLK);
      if (tog) iADC_L = ~iADC_L;
    end
  endtask

  // One BCK period: sample ADCDAT and change LRCK/DACDAT on the fall.
  task automatic slot(input logic lr, input logic d, input int idx);
    cap_sh = {cap_sh[14:0], oAUD_ADCDAT};
    if (prev_idx == 15) begin
      if (prev_lr) cap_l = cap_sh;
      else         cap_r = cap_sh;
    end
    prev_idx    = idx;
    prev_lr     = lr;
    iAUD_BCK    = 1'b0;
    iAUD_LRCK   = lr;
    iAUD_DACDAT = d;
    wait_clk(6);
    iAUD_BCK = 1'b1;
    wait_clk(6);
  endtask

  task automatic send_bits(input logic lr, input logic [15:0] w, input int first,
                           input int last, input bit t);
    for (int i = first; i <= last; i++) begin
      tog = t && (i > 0);
      slot(lr, w[15-i], i);
    end
    tog = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_bits(1'b1, l, 0, 15, 1'b0);
    send_bits(1'b0, r, 0, 15, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adcdat"}, oAUD_ADCDAT, 0);
    check({tag, "_dac_l"},  oDAC_L, 0);
    check({tag, "_dac_r"},  oDAC_R, 0);
    check({tag, "_valid"},  oDAC_VALID, 0);
    check({tag, "_err"},    oFRAME_ERR, 0);
    check({tag, "_locked"}, oLOCKED, 0);
  endtask

  typedef struct {
    logic [15:0] send_l, send_r, adc_l, adc_r;
    logic [15:0] exp_l, exp_r, exp_tx_l;
  } vec_t;

  vec_t vecs[5];
  int   v0, e0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{send_l:16'h8001, send_r:16'h7FFE, adc_l:16'hA5C3, adc_r:16'h0F0F,
                exp_l:16'h8001, exp_r:16'h7FFE, exp_tx_l:16'hA5C3};
    vecs[1] = '{send_l:16'h8001, send_r:16'h7FFE, adc_l:16'hA5C3, adc_r:16'h0F0F,
                exp_l:16'h8001, exp_r:16'h7FFE, exp_tx_l:16'hA5C3};
    vecs[2] = '{send_l:16'h1234, send_r:16'hFEDC, adc_l:16'h0000, adc_r:16'hFFFF,
                exp_l:16'h1234, exp_r:16'hFEDC, exp_tx_l:16'h0000};
    vecs[3] = '{send_l:16'hFFFF, send_r:16'h0000, adc_l:16'h8000, adc_r:16'h0001,
                exp_l:16'hFFFF, exp_r:16'h0000, exp_tx_l:16'h8000};
    vecs[4] = '{send_l:16'h5A5A, send_r:16'hA5A5, adc_l:16'h7FFF, adc_r:16'h8000,
                exp_l:16'h5A5A, exp_r:16'hA5A5, exp_tx_l:16'h7FFF};

    // Reset state.
    repeat (3) @(negedge iCLK);
    check_all_zero("reset");
    iRST = 1'b0;
    wait_clk(4);

    // Nominal frames from the table.
    for (int i = 0; i < 5; i++) begin
      iADC_L = vecs[i].adc_l;
      iADC_R = vecs[i].adc_r;
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].send_l, vecs[i].send_r);
      check($sformatf("v%0d_valid_pulses", i), valid_cnt - v0, 1);
      check($sformatf("v%0d_dac_l", i), oDAC_L, vecs[i].exp_l);
      check($sformatf("v%0d_dac_r", i), oDAC_R, vecs[i].exp_r);
      check($sformatf("v%0d_locked", i), oLOCKED, 1);
      check($sformatf("v%0d_frame_err", i), err_cnt - e0, 0);
      if (i >= 1) begin
        check($sformatf("v%0d_tx_l", i), cap_l, vecs[i].exp_tx_l);
        check($sformatf("v%0d_tx_r", i), cap_r, vecs[i-1].adc_r);
      end
    end

    // Short left word: 10 bits then an LRCK toggle.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(1'b1, 16'hBEEF, 0, 9, 1'b0);
    send_bits(1'b0, 16'h1357, 0, 15, 1'b0);
    check("short_err_pulses", err_cnt - e0, 1);
    check("short_no_valid", valid_cnt - v0, 0);
    check("short_locked", oLOCKED, 0);
    check("short_dac_l_hold", oDAC_L, 16'h5A5A);
    check("short_dac_r_hold", oDAC_R, 16'hA5A5);
    v0 = valid_cnt;
    send_frame(16'h2468, 16'hACE1);
    check("recover_valid", valid_cnt - v0, 1);
    check("recover_dac_l", oDAC_L, 16'h2468);
    check("recover_dac_r", oDAC_R, 16'hACE1);
    check("recover_locked", oLOCKED, 1);
    check("recover_err_total", err_cnt - e0, 1);

    // BCK stops for 100 clocks mid left word (ADCDAT driving a 1).
    iADC_L = 16'hFFFF;
    iADC_R = 16'h0000;
    e0 = err_cnt;
    send_bits(1'b1, 16'h0F0F, 0, 7, 1'b0);
    wait_clk(54);
    check("stall_locked_before", oLOCKED, 1);
    check("stall_adcdat_before", oAUD_ADCDAT, 1);
    wait_clk(12);
    check("stall_locked_after", oLOCKED, 0);
    check("stall_adcdat_after", oAUD_ADCDAT, 0);
    wait_clk(28);
    v0 = valid_cnt;
    send_bits(1'b1, 16'h0F0F, 8, 15, 1'b0);
    send_bits(1'b0, 16'h5555, 0, 15, 1'b0);
    check("restart_partial_no_valid", valid_cnt - v0, 0);
    send_frame(16'h0C0D, 16'hE0E1);
    check("restart_valid", valid_cnt - v0, 1);
    check("restart_dac_l", oDAC_L, 16'h0C0D);
    check("restart_dac_r", oDAC_R, 16'hE0E1);
    check("restart_locked", oLOCKED, 1);
    check("restart_no_err", err_cnt - e0, 0);

    // Reset asserted in the middle of a left word.
    iADC_L = 16'hFFFF;
    send_bits(1'b1, 16'h3333, 0, 7, 1'b0);
    check("midrst_adcdat_before", oAUD_ADCDAT, 1);
    iRST = 1'b1;
    #1;
    check_all_zero("midrst");
    wait_clk(3);
    iRST = 1'b0;
    v0 = valid_cnt;
    send_bits(1'b1, 16'h3333, 8, 15, 1'b0);
    send_bits(1'b0, 16'h4444, 0, 15, 1'b0);
    check("midrst_partial_no_valid", valid_cnt - v0, 0);
    check("midrst_dac_l_zero", oDAC_L, 0);
    check("midrst_dac_r_zero", oDAC_R, 0);
    send_frame(16'h7E57, 16'h0BAD);
    check("midrst_valid", valid_cnt - v0, 1);
    check("midrst_dac_l", oDAC_L, 16'h7E57);
    check("midrst_dac_r", oDAC_R, 16'h0BAD);
    check("midrst_locked", oLOCKED, 1);

    // iADC_L toggles every clock after the word has been loaded.
    iADC_L = 16'h3C96;
    iADC_R = 16'h0000;
    v0 = valid_cnt;
    send_bits(1'b1, 16'h1111, 0, 15, 1'b1);
    send_bits(1'b0, 16'h2222, 0, 15, 1'b0);
    check("toggle_tx_l", cap_l, 16'h3C96);
    check("toggle_valid", valid_cnt - v0, 1);
    check("toggle_dac_l", oDAC_L, 16'h1111);
    check("toggle_dac_r", oDAC_R, 16'h2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
